// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator for sobel_calc: two line buffers plus a shifting window.
// Optional start-of-frame input sof_i is enabled by defining SOBEL_WIN_SOF_EN.
module sobel_window_gen #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
`ifdef SOBEL_WIN_SOF_EN
    input  logic              sof_i,
`endif
    input  logic [DATA_W-1:0] pixel_i,
    input  logic              valid_i,
    output logic [DATA_W-1:0] d0_o,
    output logic [DATA_W-1:0] d1_o,
    output logic [DATA_W-1:0] d2_o,
    output logic [DATA_W-1:0] d3_o,
    output logic [DATA_W-1:0] d4_o,
    output logic [DATA_W-1:0] d5_o,
    output logic [DATA_W-1:0] d6_o,
    output logic [DATA_W-1:0] d7_o,
    output logic [DATA_W-1:0] d8_o,
    output logic              done_o,
    output logic              frame_done_o,
    output logic              busy_o
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q, col_d, col_cur;
    logic [RW-1:0]     row_q, row_d, row_cur;
    logic              done_q, done_d;
    logic              fdone_q, fdone_d;
    logic              sof_w;
    logic              col_last, row_last;
    logic [DATA_W-1:0] lb_a, lb_b;
    logic [DATA_W-1:0] lb1_q [IMG_W];
    logic [DATA_W-1:0] lb2_q [IMG_W];
    logic [DATA_W-1:0] win_q [9];
    logic [DATA_W-1:0] win_d [9];

`ifdef SOBEL_WIN_SOF_EN
    assign sof_w = valid_i & sof_i;
`else
    assign sof_w = 1'b0;
`endif

    // A start-of-frame pixel is treated as position (0,0) regardless of the counters.
    assign col_cur  = sof_w ? '0 : col_q;
    assign row_cur  = sof_w ? '0 : row_q;
    assign col_last = (col_cur == COL_LAST);
    assign row_last = (row_cur == ROW_LAST);

    assign lb_a = lb2_q[col_cur];
    assign lb_b = lb1_q[col_cur];

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        state_d = state_q;
        done_d  = 1'b0;
        fdone_d = 1'b0;
        if (valid_i) begin
            col_d   = col_last ? '0 : col_cur + CW'(1);
            row_d   = col_last ? (row_last ? '0 : row_cur + RW'(1)) : row_cur;
            done_d  = (row_cur >= RW'(2)) && (col_cur >= CW'(2));
            fdone_d = col_last && row_last;
            case (state_q)
                IDLE:    state_d = FILL;
                FILL:    if (col_last && (row_cur == RW'(1))) state_d = RUN;
                RUN:     if (col_last && row_last) state_d = IDLE;
                default: state_d = IDLE;
            endcase
            if (sof_w) state_d = FILL;
        end
    end

    always_comb begin
        win_d = win_q;
        if (valid_i) begin
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = lb_a;
            win_d[3] = win_q[4];
            win_d[4] = win_q[5];
            win_d[5] = lb_b;
            win_d[6] = win_q[7];
            win_d[7] = win_q[8];
            win_d[8] = pixel_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
            fdone_q <= 1'b0;
            for (int i = 0; i < 9; i++) win_q[i] <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            done_q  <= done_d;
            fdone_q <= fdone_d;
            win_q   <= win_d;
        end
    end

    // Line buffers are never cleared; both rows are rewritten before any window uses them.
    always_ff @(posedge clk) begin
        if (valid_i) begin
            lb2_q[col_cur] <= lb_b;
            lb1_q[col_cur] <= pixel_i;
        end
    end

    assign d0_o         = win_q[0];
    assign d1_o         = win_q[1];
    assign d2_o         = win_q[2];
    assign d3_o         = win_q[3];
    assign d4_o         = win_q[4];
    assign d5_o         = win_q[5];
    assign d6_o         = win_q[6];
    assign d7_o         = win_q[7];
    assign d8_o         = win_q[8];
    assign done_o       = done_q;
    assign frame_done_o = fdone_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen: a 4x4 instance and a 5x3 instance with hand-computed windows.
`timescale 1ns/1ps
module tb_sobel_window_gen;

    typedef logic [71:0] win_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] a_pix, b_pix;
    logic       a_valid, b_valid;
    logic [7:0] a_d [9];
    logic [7:0] b_d [9];
    logic       a_done, a_fd, a_busy;
    logic       b_done, b_fd, b_busy;
    win_t       a_win, b_win;
`ifdef SOBEL_WIN_SOF_EN
    logic       a_sof, b_sof, sof_req;
`endif

    assign a_win = {a_d[0], a_d[1], a_d[2], a_d[3], a_d[4], a_d[5], a_d[6], a_d[7], a_d[8]};
    assign b_win = {b_d[0], b_d[1], b_d[2], b_d[3], b_d[4], b_d[5], b_d[6], b_d[7], b_d[8]};

    sobel_window_gen #(.IMG_W(4), .IMG_H(4), .DATA_W(8)) u_dut4 (
        .clk(clk), .rst(rst),
`ifdef SOBEL_WIN_SOF_EN
        .sof_i(a_sof),
`endif
        .pixel_i(a_pix), .valid_i(a_valid),
        .d0_o(a_d[0]), .d1_o(a_d[1]), .d2_o(a_d[2]), .d3_o(a_d[3]), .d4_o(a_d[4]),
        .d5_o(a_d[5]), .d6_o(a_d[6]), .d7_o(a_d[7]), .d8_o(a_d[8]),
        .done_o(a_done), .frame_done_o(a_fd), .busy_o(a_busy)
    );

    sobel_window_gen #(.IMG_W(5), .IMG_H(3), .DATA_W(8)) u_dut5 (
        .clk(clk), .rst(rst),
`ifdef SOBEL_WIN_SOF_EN
        .sof_i(b_sof),
`endif
        .pixel_i(b_pix), .valid_i(b_valid),
        .d0_o(b_d[0]), .d1_o(b_d[1]), .d2_o(b_d[2]), .d3_o(b_d[3]), .d4_o(b_d[4]),
        .d5_o(b_d[5]), .d6_o(b_d[6]), .d7_o(b_d[7]), .d8_o(b_d[8]),
        .done_o(b_done), .frame_done_o(b_fd), .busy_o(b_busy)
    );

    int checks = 0;
    int errors = 0;

    int E4 [4][9] = '{'{1,2,3,5,6,7,9,10,11}, '{2,3,4,6,7,8,10,11,12},
                      '{5,6,7,9,10,11,13,14,15}, '{6,7,8,10,11,12,14,15,16}};
    int E5 [3][9] = '{'{1,2,3,6,7,8,11,12,13}, '{2,3,4,7,8,9,12,13,14},
                      '{3,4,5,8,9,10,13,14,15}};

    // observation records
    win_t obs_win [$];
    int   obs_tag [$];
    int   fd_cnt;
    int   fd_tag;
    logic fd_busy;
    logic busy_mid;
    int   prev_tag;

    function automatic win_t exp_win(input int shape, input int k, input int base);
        win_t w;
        w = '0;
        for (int i = 0; i < 9; i++)
            w[(8-i)*8 +: 8] = 8'(((shape == 5) ? E5[k][i] : E4[k][i]) + base);
        return w;
    endfunction

    task automatic clr();
        obs_win.delete();
        obs_tag.delete();
        fd_cnt   = 0;
        fd_tag   = -1;
        fd_busy  = 1'bx;
        busy_mid = 1'bx;
        prev_tag = 0;
    endtask

    task automatic sample(input int sel);
        win_t w;
        logic dn, fd, bz;
        w  = (sel == 0) ? a_win  : b_win;
        dn = (sel == 0) ? a_done : b_done;
        fd = (sel == 0) ? a_fd   : b_fd;
        bz = (sel == 0) ? a_busy : b_busy;
        if (dn === 1'b1) begin
            obs_win.push_back(w);
            obs_tag.push_back(prev_tag);
        end
        if (fd === 1'b1) begin
            fd_cnt++;
            fd_tag  = prev_tag;
            fd_busy = bz;
        end
        if (prev_tag == 8) busy_mid = bz;
    endtask

    task automatic drive(input int sel, input logic v, input int pix, input int tag);
        @(negedge clk);
        sample(sel);
        prev_tag = v ? tag : 0;
        a_valid  = (sel == 0) && v;
        b_valid  = (sel == 1) && v;
        a_pix    = 8'(pix);
        b_pix    = 8'(pix);
`ifdef SOBEL_WIN_SOF_EN
        a_sof    = (sel == 0) && v && sof_req;
`endif
    endtask

    task automatic idle(input int sel, input int n);
        repeat (n) drive(sel, 1'b0, 0, 0);
    endtask

    task automatic stream(input int sel, input int base, input int tag0, input int n, input int gap);
        for (int p = 1; p <= n; p++) begin
            drive(sel, 1'b1, base + p, tag0 + p);
            if (gap > 0 && (p % 2) == 0) idle(sel, gap);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (a_win !== '0) begin errors++; $display("FAIL reset_win4: got %h expected 0", a_win); end
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done4: got %b expected 0", a_done); end
        checks++; if (a_fd !== 1'b0) begin errors++; $display("FAIL reset_fd4: got %b expected 0", a_fd); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy4: got %b expected 0", a_busy); end
        checks++; if (b_win !== '0) begin errors++; $display("FAIL reset_win5: got %h expected 0", b_win); end
        checks++; if (b_done !== 1'b0) begin errors++; $display("FAIL reset_done5: got %b expected 0", b_done); end
        checks++; if (b_fd !== 1'b0) begin errors++; $display("FAIL reset_fd5: got %b expected 0", b_fd); end
        checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL reset_busy5: got %b expected 0", b_busy); end
        rst = 1'b1;
    endtask

    task automatic test_stream();
        int exp_tag [4] = '{11, 12, 15, 16};
        clr();
        stream(0, 0, 0, 16, 0);
        idle(0, 3);
        checks++; if (obs_win.size() != 4) begin errors++; $display("FAIL stream_count: got %0d strobes expected 4", obs_win.size()); end
        for (int k = 0; k < 4; k++) begin
            win_t w = (k < obs_win.size()) ? obs_win[k] : 'x;
            int   t = (k < obs_tag.size()) ? obs_tag[k] : -1;
            checks++; if (w !== exp_win(4, k, 0)) begin errors++; $display("FAIL stream_win%0d: got %h expected %h", k, w, exp_win(4, k, 0)); end
            checks++; if (t != exp_tag[k]) begin errors++; $display("FAIL stream_pos%0d: after pixel %0d expected %0d", k, t, exp_tag[k]); end
        end
        checks++; if (fd_cnt != 1) begin errors++; $display("FAIL stream_fdcnt: got %0d expected 1", fd_cnt); end
        checks++; if (fd_tag != 16) begin errors++; $display("FAIL stream_fdpos: after pixel %0d expected 16", fd_tag); end
        checks++; if (fd_busy !== 1'b0) begin errors++; $display("FAIL stream_busy_end: got %b expected 0", fd_busy); end
        checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL stream_busy_mid: got %b expected 1", busy_mid); end
    endtask

    task automatic test_gaps();
        int exp_tag [4] = '{11, 12, 15, 16};
        clr();
        stream(0, 0, 0, 16, 3);
        idle(0, 3);
        checks++; if (obs_win.size() != 4) begin errors++; $display("FAIL gaps_count: got %0d strobes expected 4", obs_win.size()); end
        for (int k = 0; k < 4; k++) begin
            win_t w = (k < obs_win.size()) ? obs_win[k] : 'x;
            int   t = (k < obs_tag.size()) ? obs_tag[k] : -1;
            checks++; if (w !== exp_win(4, k, 0)) begin errors++; $display("FAIL gaps_win%0d: got %h expected %h", k, w, exp_win(4, k, 0)); end
            checks++; if (t != exp_tag[k]) begin errors++; $display("FAIL gaps_pos%0d: after pixel %0d expected %0d", k, t, exp_tag[k]); end
        end
        checks++; if (fd_cnt != 1) begin errors++; $display("FAIL gaps_fdcnt: got %0d expected 1", fd_cnt); end
        checks++; if (fd_tag != 16) begin errors++; $display("FAIL gaps_fdpos: after pixel %0d expected 16", fd_tag); end
    endtask

    task automatic test_back_to_back();
        int exp_tag [8] = '{11, 12, 15, 16, 27, 28, 31, 32};
        clr();
        stream(0, 0, 0, 16, 0);
        stream(0, 100, 16, 16, 0);
        idle(0, 3);
        checks++; if (obs_win.size() != 8) begin errors++; $display("FAIL b2b_count: got %0d strobes expected 8", obs_win.size()); end
        for (int k = 0; k < 8; k++) begin
            win_t w = (k < obs_win.size()) ? obs_win[k] : 'x;
            int   t = (k < obs_tag.size()) ? obs_tag[k] : -1;
            win_t e = exp_win(4, k % 4, (k < 4) ? 0 : 100);
            checks++; if (w !== e) begin errors++; $display("FAIL b2b_win%0d: got %h expected %h", k, w, e); end
            checks++; if (t != exp_tag[k]) begin errors++; $display("FAIL b2b_pos%0d: after pixel %0d expected %0d", k, t, exp_tag[k]); end
        end
        checks++; if (fd_cnt != 2) begin errors++; $display("FAIL b2b_fdcnt: got %0d expected 2", fd_cnt); end
        checks++; if (fd_tag != 32) begin errors++; $display("FAIL b2b_fdpos: after pixel %0d expected 32", fd_tag); end
    endtask

    task automatic test_reset_mid();
        int exp_tag [4] = '{11, 12, 15, 16};
        clr();
        stream(0, 0, -100, 7, 0);
        @(negedge clk);
        a_valid = 1'b0;
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_pre: got %b expected 1", a_busy); end
        rst = 1'b0;
        #1;
        checks++; if (a_win !== '0) begin errors++; $display("FAIL rstmid_win: got %h expected 0", a_win); end
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", a_done); end
        checks++; if (a_fd !== 1'b0) begin errors++; $display("FAIL rstmid_fd: got %b expected 0", a_fd); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", a_busy); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clr();
        stream(0, 0, 0, 16, 0);
        idle(0, 3);
        checks++; if (obs_win.size() != 4) begin errors++; $display("FAIL rstmid_count: got %0d strobes expected 4", obs_win.size()); end
        for (int k = 0; k < 4; k++) begin
            win_t w = (k < obs_win.size()) ? obs_win[k] : 'x;
            int   t = (k < obs_tag.size()) ? obs_tag[k] : -1;
            checks++; if (w !== exp_win(4, k, 0)) begin errors++; $display("FAIL rstmid_win%0d: got %h expected %h", k, w, exp_win(4, k, 0)); end
            checks++; if (t != exp_tag[k]) begin errors++; $display("FAIL rstmid_pos%0d: after pixel %0d expected %0d", k, t, exp_tag[k]); end
        end
        checks++; if (fd_cnt != 1) begin errors++; $display("FAIL rstmid_fdcnt: got %0d expected 1", fd_cnt); end
    endtask

    task automatic test_odd_shape();
        int exp_tag [3] = '{13, 14, 15};
        clr();
        stream(1, 0, 0, 15, 0);
        idle(1, 3);
        checks++; if (obs_win.size() != 3) begin errors++; $display("FAIL odd_count: got %0d strobes expected 3", obs_win.size()); end
        for (int k = 0; k < 3; k++) begin
            win_t w = (k < obs_win.size()) ? obs_win[k] : 'x;
            int   t = (k < obs_tag.size()) ? obs_tag[k] : -1;
            checks++; if (w !== exp_win(5, k, 0)) begin errors++; $display("FAIL odd_win%0d: got %h expected %h", k, w, exp_win(5, k, 0)); end
            checks++; if (t != exp_tag[k]) begin errors++; $display("FAIL odd_pos%0d: after pixel %0d expected %0d", k, t, exp_tag[k]); end
        end
        checks++; if (fd_cnt != 1) begin errors++; $display("FAIL odd_fdcnt: got %0d expected 1", fd_cnt); end
        checks++; if (fd_tag != 15) begin errors++; $display("FAIL odd_fdpos: after pixel %0d expected 15", fd_tag); end
    endtask

`ifdef SOBEL_WIN_SOF_EN
    task automatic test_sof();
        int exp_tag [4] = '{11, 12, 15, 16};
        clr();
        stream(0, 0, -100, 6, 0);
        sof_req = 1'b1;
        drive(0, 1'b1, 1, 1);
        sof_req = 1'b0;
        for (int p = 2; p <= 16; p++) drive(0, 1'b1, p, p);
        idle(0, 3);
        checks++; if (obs_win.size() != 4) begin errors++; $display("FAIL sof_count: got %0d strobes expected 4", obs_win.size()); end
        for (int k = 0; k < 4; k++) begin
            win_t w = (k < obs_win.size()) ? obs_win[k] : 'x;
            int   t = (k < obs_tag.size()) ? obs_tag[k] : -1;
            checks++; if (w !== exp_win(4, k, 0)) begin errors++; $display("FAIL sof_win%0d: got %h expected %h", k, w, exp_win(4, k, 0)); end
            checks++; if (t != exp_tag[k]) begin errors++; $display("FAIL sof_pos%0d: after pixel %0d expected %0d", k, t, exp_tag[k]); end
        end
        checks++; if (fd_cnt != 1) begin errors++; $display("FAIL sof_fdcnt: got %0d expected 1", fd_cnt); end
        checks++; if (fd_tag != 16) begin errors++; $display("FAIL sof_fdpos: after pixel %0d expected 16", fd_tag); end
    endtask
`endif

    initial begin
        rst     = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_pix   = '0;
        b_pix   = '0;
`ifdef SOBEL_WIN_SOF_EN
        a_sof   = 1'b0;
        b_sof   = 1'b0;
        sof_req = 1'b0;
`endif
        clr();
        test_reset();
        test_stream();
        test_gaps();
        test_back_to_back();
        test_reset_mid();
        test_odd_shape();
`ifdef SOBEL_WIN_SOF_EN
        test_sof();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
